// File: rtl/tick_prescaler.sv
// tick_prescaler
//
// Runtime-programmable time-base generator. A base counter divides clk by
// div_q to make a one-cycle base strobe. That strobe then feeds a chain of
// STAGES counters, each dividing by STAGE_DIV, so a single block yields
// every strobe rate (ms, 10 ms, 100 ms, s, ...).
//
// Ports:
//   clk       in   single clock
//   reset     in   synchronous, active-high reset
//   enable    in   count when high; all counters hold when low
//   clear     in   zero all counters and ticks; divisor kept
//   div_load  in   load max(div_in,1) into the divisor and restart the base phase
//   div_in    in   [CNT_W-1:0] new base period in clk cycles
//   tick      out  [STAGES:0] registered one-cycle strobes; bit 0 is the base,
//                  bit k is stage k
//   div_q     out  [CNT_W-1:0] divisor currently in use
//
// Per-cycle priority: reset > clear/div_load > counting. When clear and
// div_load arrive together, both take effect.
module tick_prescaler #(
  parameter int CNT_W       = 20,
  parameter int DEFAULT_DIV = 500000,
  parameter int STAGES      = 3,
  parameter int STAGE_DIV   = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_in,
  output logic [STAGES:0]  tick,
  output logic [CNT_W-1:0] div_q
);

  localparam int SW = (STAGE_DIV > 1) ? $clog2(STAGE_DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_RST    = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [SW-1:0]    STAGE_LAST = SW'(STAGE_DIV - 1);
  localparam logic [SW-1:0]    STAGE_ONE  = SW'(1);

  logic [CNT_W-1:0] c0;
  logic [SW-1:0]    cs [1:STAGES];
  // w[k] is the wrap strobe of stage k in the current cycle.
  logic [STAGES:0]  w;

  // Wrap chain. A load or clear restarts the phase, so counting (and
  // therefore every wrap) is suppressed in that cycle. A block-local carry
  // keeps the chain free of a self-referencing vector.
  always_comb begin
    logic carry;
    w     = '0;
    carry = enable & ~clear & ~div_load & (c0 == (div_q - ONE));
    w[0]  = carry;
    for (int k = 1; k <= STAGES; k++) begin
      carry = carry & (cs[k] == STAGE_LAST);
      w[k]  = carry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c0    <= '0;
      tick  <= '0;
      div_q <= DIV_RST;
      for (int k = 1; k <= STAGES; k++) cs[k] <= '0;
    end else begin
      // Ticks are the registered wrap strobes; w is already zero while
      // disabled, cleared or loading.
      tick <= w;

      // A zero divisor would never wrap; treat it as the fastest rate instead.
      if (div_load) div_q <= (div_in == '0) ? ONE : div_in;

      if (clear) begin
        c0 <= '0;
        for (int k = 1; k <= STAGES; k++) cs[k] <= '0;
      end else if (div_load) begin
        // Only the base phase restarts; stage phases survive a reload.
        c0 <= '0;
      end else if (enable) begin
        c0 <= w[0] ? '0 : c0 + ONE;
        for (int k = 1; k <= STAGES; k++) begin
          if (w[k-1]) cs[k] <= w[k] ? '0 : cs[k] + STAGE_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_tick_prescaler.sv
// Bench for tick_prescaler with CNT_W=8, DEFAULT_DIV=4, STAGES=2, STAGE_DIV=3.
// The driver issues one cycle of inputs per step and queues the tick/div_q
// values required after that edge; the monitor pops one entry after every
// clock edge and compares it against the DUT outputs.
module tb_tick_prescaler;

  localparam int CNT_W = 8;
  localparam int DEF   = 4;
  localparam int ST    = 2;
  localparam int SDIV  = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             clear = 1'b0;
  logic             div_load = 1'b0;
  logic [CNT_W-1:0] div_in = '0;
  logic [ST:0]      tick;
  logic [CNT_W-1:0] div_q;

  int    checks = 0;
  int    errors = 0;
  int    step_no = 0;
  string scen = "init";

  // Entry layout: {tick[2:0], div_q[7:0]}
  logic [ST+CNT_W:0] exp_q[$];

  tick_prescaler #(
    .CNT_W(CNT_W), .DEFAULT_DIV(DEF), .STAGES(ST), .STAGE_DIV(SDIV)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .div_load(div_load), .div_in(div_in), .tick(tick), .div_q(div_q)
  );

  // Clock
  always #5 clk = ~clk;

  // Driver: apply inputs away from the edge, queue the required outputs.
  task automatic step(input logic r, input logic en, input logic clr,
                      input logic ld, input logic [CNT_W-1:0] din,
                      input logic [ST:0] et, input logic [CNT_W-1:0] ed);
    @(negedge clk);
    reset    = r;
    enable   = en;
    clear    = clr;
    div_load = ld;
    div_in   = din;
    exp_q.push_back({et, ed});
    @(posedge clk);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, CNT_W'(DEF));
  endtask

  // Monitor / scoreboard
  initial begin
    logic [ST+CNT_W:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        step_no++;
        checks++;
        if (tick !== e[ST+CNT_W:CNT_W]) begin
          errors++;
          $display("FAIL %s tick step %0d: got %b expected %b",
                   scen, step_no, tick, e[ST+CNT_W:CNT_W]);
        end
        checks++;
        if (div_q !== e[CNT_W-1:0]) begin
          errors++;
          $display("FAIL %s div_q step %0d: got %0d expected %0d",
                   scen, step_no, div_q, e[CNT_W-1:0]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [ST:0] et;

    // Reset values
    scen = "reset";
    do_reset();
    do_reset();

    // Free run, DIV=4: tick0 every 4, tick1 every 12, tick2 at 36
    scen = "free_run";
    for (int n = 1; n <= 40; n++) begin
      et[0] = (n % 4 == 0);
      et[1] = (n % 12 == 0);
      et[2] = (n % 36 == 0);
      step(1'b0, 1'b1, 1'b0, 1'b0, '0, et, 8'd4);
    end

    // Pause: enable low on edges 3..7, period stretched by 5
    scen = "pause";
    do_reset();
    for (int n = 1; n <= 20; n++) begin
      et = '0;
      if (n >= 8) begin
        et[0] = ((n - 5) % 4 == 0);
        et[1] = ((n - 5) % 12 == 0);
      end
      step(1'b0, !(n >= 3 && n <= 7), 1'b0, 1'b0, '0, et, 8'd4);
    end

    // Reload: tick0 at 4 (stage1 count 1), load 6 at edge 5, load 2 at
    // edge 8; stage1 count survives, so tick1 arrives at edge 12.
    scen = "reload";
    do_reset();
    for (int n = 1; n <= 16; n++) begin
      logic             ld;
      logic [CNT_W-1:0] din;
      logic [CNT_W-1:0] ed;
      ld  = (n == 5) || (n == 8);
      din = (n == 5) ? 8'd6 : 8'd2;
      ed  = (n < 5) ? 8'd4 : (n < 8) ? 8'd6 : 8'd2;
      et  = '0;
      et[0] = (n == 4) || (n >= 10 && n % 2 == 0);
      et[1] = (n == 12);
      step(1'b0, 1'b1, 1'b0, ld, din, et, ed);
    end

    // Zero divisor loads as 1: tick0 every cycle, tick1 every 3, tick2 every 9
    scen = "zero_div";
    do_reset();
    for (int n = 1; n <= 10; n++) begin
      et = '0;
      if (n >= 2) begin
        et[0] = 1'b1;
        et[1] = ((n - 1) % 3 == 0);
        et[2] = ((n - 1) % 9 == 0);
      end
      step(1'b0, 1'b1, 1'b0, (n == 1), '0, et, (n == 1) ? 8'd1 : 8'd1);
    end

    // Clear with enable low at edge 7, re-enable at edge 10
    scen = "clear";
    do_reset();
    for (int n = 1; n <= 21; n++) begin
      et = '0;
      et[0] = (n == 4) || (n == 13) || (n == 17) || (n == 21);
      et[1] = (n == 21);
      step(1'b0, (n <= 6) || (n >= 10), (n == 7), 1'b0, '0, et, 8'd4);
    end

    // Reset during a tick1 pulse; divisor returns to default
    scen = "reset_mid";
    do_reset();
    for (int n = 1; n <= 10; n++) begin
      et = '0;
      et[0] = (n == 4) || (n == 7) || (n == 10);
      et[1] = (n == 10);
      step(1'b0, 1'b1, 1'b0, (n == 1), 8'd3, et, (n == 1) ? 8'd3 : 8'd3);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, 3'b000, 8'd4);

    // Combined clear + load 3 at edge 6
    scen = "combined";
    do_reset();
    for (int n = 1; n <= 12; n++) begin
      et = '0;
      et[0] = (n == 4) || (n == 9) || (n == 12);
      step(1'b0, 1'b1, (n == 6), (n == 6), 8'd3, et, (n < 6) ? 8'd4 : 8'd3);
    end

    // Drain and report
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_prescaler.md
# tick_prescaler

Parametrised, runtime-programmable tick generator for the watch controller. It divides `clk` into a base one-cycle tick, then cascades that tick through `STAGES` decimal-style counters so that every time-base strobe is produced by one block: ms, 10 ms, 100 ms, s and so on. The divisor is loadable at run time, counting can be paused and the phase can be cleared. The block feeds the stopwatch, clock-update and display-blink logic.

## Interface
- `CNT_W`, 20: width of the base divisor and base counter.
- `DEFAULT_DIV`, 500000: base period in `clk` cycles after reset. Must be ≥1 and < 2^CNT_W.
- `STAGES`, 3: number of cascaded stages after the base stage. Must be ≥1.
- `STAGE_DIV`, 10: base-or-previous ticks per tick of each cascaded stage. Must be ≥2.

Ports:
- `clk` input, 1: single clock.
- `reset` input, 1: **synchronous, active-high** reset.
- `enable` input, 1: count when high; hold all counters when low.
- `clear` input, 1: synchronous phase restart. Zeroes all counters and ticks; the divisor is kept.
- `div_load` input, 1: load `div_in` into the base divisor register.
- `div_in` input, CNT_W: new base period in cycles.
- `tick` output, STAGES+1: `tick[0]` is the base strobe; `tick[k]` is the stage-k strobe. Every bit is a one-cycle pulse.
- `div_q` output, CNT_W: divisor currently in use.

## Operation
- **Reset values.**
  - `tick` = 0.
  - Base counter = 0 and all stage counters = 0.
  - `div_q` = `DEFAULT_DIV`.
- **Priority per cycle:** `reset` > `clear`/`div_load` > counting.
- **Base stage.**
  - Counter `c0` runs over 0..div_q−1 and advances once per cycle in which `enable` = 1.
  - On an enabled cycle with `c0` = div_q−1: `c0` ← 0, the wrap strobe `w0` = 1, and `tick[0]` is registered to 1 for the next cycle.
- **Stage k (1..STAGES).**
  - Counter `ck` runs over 0..STAGE_DIV−1 and advances only in cycles where `w(k−1)` = 1.
  - At `ck` = STAGE_DIV−1 together with `w(k−1)`: `ck` ← 0, `wk` = 1, and `tick[k]` is registered to 1.
  - Consequence: `tick[k]` always coincides with a `tick[k−1]` pulse.
- **Tick outputs.** All `tick` bits are registered. They are 0 in every cycle not following a wrap, including every cycle while `enable` = 0.
- **`div_load`.**
  - `div_q` ← max(`div_in`, 1), so 0 loads as 1.
  - `c0` ← 0 and `tick[0]` ← 0 in the same cycle.
  - Stage counters are untouched.
  - Loading is independent of `enable`.
- **`div_q` = 1.** `tick[0]` is high in every cycle following an enabled cycle.
- **`clear`.**
  - All counters ← 0 and all `tick` ← 0.
  - `div_q` is unchanged.
  - `clear` works with `enable` low.
- **Simultaneous `clear` and `div_load`:** both take effect, i.e. counters are zeroed and the divisor is loaded.
- **`enable` falling mid-period.** Counters hold their values and resume from the held phase. The period is stretched by exactly the number of disabled cycles.
- **No saturation or overflow.** Counters wrap only as described. `div_in` ≥ 2^CNT_W cannot occur because of the port width.

## Timing
- Base period is exactly `div_q` enabled cycles; each pulse is 1 cycle wide.
- Numbering the first rising edge with `reset` low as edge 1, with `enable` held high:
  - `tick[0]` is high in the cycle after edges div_q, 2·div_q, and so on.
  - `tick[k]` period is div_q·STAGE_DIV^k cycles.
- Latency from the counting edge to `tick` = 1 cycle.
- After `div_load`/`clear` at edge n (with `enable` = 1), the next `tick[0]` follows edge n+div_q.
- `div_q` updates at the edge that samples `div_load`.
- `reset` asserted mid-pulse: `tick` = 0 in the following cycle.

## Test plan
- **Free run.** DIV=4, STAGES=2, STAGE_DIV=3, `enable`=1 after reset. Required: `tick[0]` after edges 4, 8, 12…; `tick[1]` after edges 12, 24… (coincident with `tick[0]`); `tick[2]` after edge 36 only within 40 cycles.
- **Pause.** DIV=4. Drop `enable` after edge 2 for 5 cycles. Required: no ticks during the pause; next `tick[0]` after edge 9, then every 4 cycles.
- **Reload.** DIV=6. Assert `div_load` with `div_in`=2 at edge 3. Required: `div_q`=2 after edge 3; `tick[0]` after edges 5, 7, 9; stage counters keep their values.
- **Zero divisor.** `div_in`=0 with `div_load`. Required: `div_q`=1; `tick[0]` high every cycle while `enable`=1; `tick[1]` every STAGE_DIV cycles.
- **Clear and reset.** `clear` with `enable`=0, then re-enable. Required: ticks 0; first `tick[0]` DIV cycles after re-enable.
- **Reset during a `tick[1]` pulse.** Required: all ticks 0 next cycle; `div_q` = `DEFAULT_DIV`.
- **Combined.** `clear` and `div_load` (`div_in`=3) in the same cycle. Required: counters 0, `div_q`=3, next `tick[0]` 3 cycles later.
